// File: rtl/lcd_char_buf_ctrl.sv
// ----------------------------------------------------------------------------
// lcd_char_buf_ctrl
//
// Character-buffer controller between the RS485 receive path and the RGB LCD
// character display. Two requesters share one COLS x ROWS text buffer:
// received bytes, and four debounced key commands (clear, freeze, home,
// newline). The display pixel generator scans the buffer through a
// registered read port.
//
// Ports:
//   sys_clk    in   1  system clock
//   sys_rst_n  in   1  asynchronous active-low reset
//   key        in   4  raw push buttons, active-low (0 clear, 1 freeze,
//                      2 home, 3 newline)
//   rx_valid   in   1  received byte strobe
//   rx_data    in   8  received byte
//   rx_ready   out  1  byte accepted in any cycle with rx_valid && rx_ready
//   rd_addr    in   5  display read address (row*COLS+col)
//   rd_data    out  8  buffer character, 1-cycle latency
//   cur_pos    out  5  current cursor address
//   frozen     out  1  received bytes are consumed but not written
//   busy       out  1  clear sequence in progress
//   drop_cnt   out  8  (only with RX_DROP_CNT_EN) saturating count of
//                      cycles with rx_valid high and rx_ready low
//
// Optional feature macro: RX_DROP_CNT_EN
// ----------------------------------------------------------------------------
module lcd_char_buf_ctrl #(
  parameter int COLS    = 16,
  parameter int ROWS    = 2,
  parameter int DEB_CNT = 1_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [4:0] cur_pos,
  output logic       frozen,
  output logic       busy
`ifdef RX_DROP_CNT_EN
  ,
  output logic [7:0] drop_cnt
`endif
);

  localparam int NCELLS = COLS * ROWS;
  localparam int CW     = (DEB_CNT > 1) ? $clog2(DEB_CNT + 1) : 1;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  // --------------------------------------------------------------------------
  // Key conditioning: synchronizer, debounce counter, press detector per key
  // --------------------------------------------------------------------------
  logic [3:0] key_press;

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    logic          meta_reg;
    logic          sync_reg;
    logic          deb_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        meta_reg  <= 1'b1;
        sync_reg  <= 1'b1;
        deb_reg   <= 1'b1;
        press_reg <= 1'b0;
        cnt_reg   <= '0;
      end else begin
        meta_reg  <= key[gi];
        sync_reg  <= meta_reg;
        press_reg <= 1'b0;
        if (sync_reg == deb_reg) begin
          // Any agreement restarts the stability window.
          cnt_reg <= '0;
        end else if (cnt_reg == CW'(DEB_CNT - 1)) begin
          deb_reg   <= sync_reg;
          cnt_reg   <= '0;
          // Only the released -> pressed edge is a command.
          press_reg <= ~sync_reg;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end

    assign key_press[gi] = press_reg;
  end

  // Fixed priority: key0 > key1 > key2 > key3; losers are dropped.
  logic sel_clear, sel_freeze, sel_home, sel_newline, any_press;
  assign sel_clear   = key_press[0];
  assign sel_freeze  = key_press[1] & ~key_press[0];
  assign sel_home    = key_press[2] & ~(|key_press[1:0]);
  assign sel_newline = key_press[3] & ~(|key_press[2:0]);
  assign any_press   = |key_press;

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  state_t     state_reg,   state_next;
  logic [4:0] cur_pos_reg, cur_pos_next;
  logic       frozen_reg,  frozen_next;
  logic [4:0] clr_idx_reg, clr_idx_next;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       accept;

  // Start of the row after the one holding pos; last row wraps to 0.
  function automatic logic [4:0] next_row(input logic [4:0] pos);
    int row;
    row = int'(pos) / COLS;
    if (row >= ROWS - 1) return 5'd0;
    return 5'((row + 1) * COLS);
  endfunction

  function automatic logic [4:0] advance(input logic [4:0] pos);
    if (pos == 5'(NCELLS - 1)) return 5'd0;
    return pos + 5'd1;
  endfunction

  assign rx_ready = (state_reg == S_IDLE) && !any_press;
  assign accept   = rx_valid && rx_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg   <= S_IDLE;
      cur_pos_reg <= '0;
      frozen_reg  <= 1'b0;
      clr_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cur_pos_reg <= cur_pos_next;
      frozen_reg  <= frozen_next;
      clr_idx_reg <= clr_idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cur_pos_next = cur_pos_reg;
    frozen_next  = frozen_reg;
    clr_idx_next = clr_idx_reg;
    wr_en        = 1'b0;
    wr_addr      = cur_pos_reg;
    wr_data      = 8'h20;

    if (sel_freeze) frozen_next = ~frozen_reg;

    case (state_reg)
      S_IDLE: begin
        if (sel_clear) begin
          state_next   = S_CLEAR;
          clr_idx_next = '0;
        end else if (sel_home) begin
          cur_pos_next = '0;
        end else if (sel_newline) begin
          cur_pos_next = next_row(cur_pos_reg);
        end else if (accept && !frozen_reg) begin
          if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
            wr_en        = 1'b1;
            wr_data      = rx_data;
            cur_pos_next = advance(cur_pos_reg);
          end else begin
            case (rx_data)
              8'h0D: cur_pos_next = next_row(cur_pos_reg);
              8'h0A: ;
              8'h08: begin
                // Backspace erases the cell it moves onto; no wrap at 0.
                if (cur_pos_reg != 5'd0) begin
                  cur_pos_next = cur_pos_reg - 5'd1;
                  wr_en        = 1'b1;
                  wr_addr      = cur_pos_reg - 5'd1;
                end
              end
              default: begin
                wr_en        = 1'b1;
                wr_data      = 8'h3F;
                cur_pos_next = advance(cur_pos_reg);
              end
            endcase
          end
        end
      end
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_idx_reg;
        if (clr_idx_reg == 5'(NCELLS - 1)) begin
          state_next   = S_IDLE;
          cur_pos_next = '0;
        end else begin
          clr_idx_next = clr_idx_reg + 5'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Text buffer with registered read. Reset must restore spaces, so the
  // storage is kept in flops rather than an uninitialised RAM.
  // --------------------------------------------------------------------------
  logic [7:0] buf_mem [NCELLS];
  logic [7:0] rd_data_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NCELLS; i++) buf_mem[i] <= 8'h20;
      rd_data_reg <= 8'h20;
    end else begin
      if (wr_en) buf_mem[wr_addr] <= wr_data;
      rd_data_reg <= ({1'b0, rd_addr} < 6'(NCELLS)) ? buf_mem[rd_addr] : 8'h20;
    end
  end

`ifdef RX_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      drop_cnt_reg <= '0;
    end else if (state_reg == S_IDLE && sel_clear) begin
      drop_cnt_reg <= '0;
    end else if (rx_valid && !rx_ready && drop_cnt_reg != 8'hFF) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`endif

  assign rd_data = rd_data_reg;
  assign cur_pos = cur_pos_reg;
  assign frozen  = frozen_reg;
  assign busy    = (state_reg == S_CLEAR);

endmodule

// File: tb/tb_lcd_char_buf_ctrl.sv
module tb_lcd_char_buf_ctrl;

  localparam int DEB = 8;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key       = 4'hF;
  logic       rx_valid  = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       rx_ready;
  logic [4:0] rd_addr   = 5'd0;
  logic [7:0] rd_data;
  logic [4:0] cur_pos;
  logic       frozen;
  logic       busy;
`ifdef RX_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  lcd_char_buf_ctrl #(
    .COLS    (16),
    .ROWS    (2),
    .DEB_CNT (DEB)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key       (key),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .cur_pos   (cur_pos),
    .frozen    (frozen),
    .busy      (busy)
`ifdef RX_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [7:0] data;
    int         fill;
    logic [4:0] exp_cur;
    logic [4:0] chk_addr;
    logic [7:0] exp_cell;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic read_cell(input logic [4:0] a, output logic [7:0] d);
    rd_addr = a;
    tick();
    d = rd_data;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    check("rx_ready_before_send", rx_ready, 1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic press_key(input int k);
    key[k] = 1'b0;
    repeat (DEB + 2) tick();
    key[k] = 1'b1;
    repeat (DEB + 6) tick();
  endtask

  initial begin
    logic [7:0] d;
    int found, n, hi, busy_seen;

    // {byte, filler bytes sent first, expected cursor, cell to read, expected cell}
    vecs[0]  = '{8'h41, 0,  5'd1,  5'd0,  8'h41};
    vecs[1]  = '{8'h42, 0,  5'd2,  5'd1,  8'h42};
    vecs[2]  = '{8'h0D, 0,  5'd16, 5'd1,  8'h42};
    vecs[3]  = '{8'h08, 0,  5'd15, 5'd15, 8'h20};
    vecs[4]  = '{8'h0A, 0,  5'd15, 5'd15, 8'h20};
    vecs[5]  = '{8'h0D, 0,  5'd16, 5'd16, 8'h20};
    vecs[6]  = '{8'h43, 15, 5'd0,  5'd31, 8'h43};
    vecs[7]  = '{8'h07, 0,  5'd1,  5'd0,  8'h3F};
    vecs[8]  = '{8'h7F, 0,  5'd2,  5'd1,  8'h3F};
    vecs[9]  = '{8'h7E, 0,  5'd3,  5'd2,  8'h7E};
    vecs[10] = '{8'h08, 0,  5'd2,  5'd2,  8'h20};
    vecs[11] = '{8'h08, 0,  5'd1,  5'd1,  8'h20};
    vecs[12] = '{8'h08, 0,  5'd0,  5'd0,  8'h20};
    vecs[13] = '{8'h08, 0,  5'd0,  5'd31, 8'h43};
    vecs[14] = '{8'h0D, 0,  5'd16, 5'd30, 8'h2E};
    vecs[15] = '{8'h0D, 0,  5'd0,  5'd16, 8'h2E};
    vecs[16] = '{8'h1F, 0,  5'd1,  5'd0,  8'h3F};
    vecs[17] = '{8'h80, 0,  5'd2,  5'd1,  8'h3F};
    vecs[18] = '{8'h20, 0,  5'd3,  5'd2,  8'h20};

    // Reset values
    repeat (3) tick();
    check("reset_rd_data", rd_data, 8'h20);
    check("reset_cur_pos", cur_pos, 0);
    check("reset_busy", busy, 0);
    check("reset_frozen", frozen, 0);
    sys_rst_n = 1'b1;
    tick();
    check("rx_ready_after_reset", rx_ready, 1);
    for (int a = 0; a < 32; a++) begin
      read_cell(5'(a), d);
      check($sformatf("reset_cell_%0d", a), d, 8'h20);
    end
    $display("reset: all cells read back, cur_pos=%0d busy=%0d", cur_pos, busy);

    // Byte stream vectors
    for (int v = 0; v < 19; v++) begin
      for (int f = 0; f < vecs[v].fill; f++) send(8'h2E);
      send(vecs[v].data);
      check($sformatf("vec%0d_cur_pos", v), cur_pos, vecs[v].exp_cur);
      read_cell(vecs[v].chk_addr, d);
      check($sformatf("vec%0d_cell", v), d, vecs[v].exp_cell);
      $display("vec %0d: byte 0x%02h -> cur_pos=%0d cell[%0d]=0x%02h", v,
               vecs[v].data, cur_pos, vecs[v].chk_addr, d);
    end

    // Short key0 glitch must be filtered out
    key[0] = 1'b0;
    repeat (4) tick();
    key[0] = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy) busy_seen++;
    end
    check("glitch_no_busy", busy_seen, 0);
    check("glitch_cur_pos", cur_pos, 3);
    read_cell(5'd0, d);
    check("glitch_cell0", d, 8'h3F);
    $display("glitch: busy cycles=%0d cur_pos=%0d", busy_seen, cur_pos);

    // Newline and home keys
    press_key(3);
    check("key3_newline", cur_pos, 16);
    press_key(3);
    check("key3_wrap", cur_pos, 0);
    send(8'h41);
    check("send_after_newline", cur_pos, 1);
    press_key(2);
    check("key2_home", cur_pos, 0);
    read_cell(5'd0, d);
    check("home_keeps_cell0", d, 8'h41);
    $display("keys: newline/home done, cur_pos=%0d", cur_pos);

    // Clear command with rx_valid held throughout
    key[0] = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      if (i == DEB + 2) key[0] = 1'b1;
      tick();
      if (busy) found = 1;
    end
    key[0] = 1'b1;
    check("clear_started", found, 1);
    if (found == 1) begin
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      n  = 0;
      hi = 0;
      while (busy && n < 100) begin
        if (rx_ready) hi++;
        n++;
        tick();
      end
      rx_valid = 1'b0;
      check("clear_busy_cycles", n, 32);
      check("clear_rx_ready_low", hi, 0);
`ifdef RX_DROP_CNT_EN
      check("drop_cnt_after_clear", drop_cnt, 32);
`endif
      check("clear_cur_pos", cur_pos, 0);
      for (int a = 0; a < 32; a++) begin
        read_cell(5'(a), d);
        check($sformatf("clear_cell_%0d", a), d, 8'h20);
      end
      $display("clear: busy for %0d cycles, cur_pos=%0d", n, cur_pos);
    end
    repeat (DEB + 6) tick();

    // key1 pulse collides with a byte: key wins, byte taken next cycle frozen
    key[1] = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      if (i == DEB + 2) key[1] = 1'b1;
      tick();
      if (!rx_ready) found = 1;
    end
    key[1] = 1'b1;
    check("key1_pulse_seen", found, 1);
    rx_valid = 1'b1;
    rx_data  = 8'h44;
    check("frozen_before_toggle", frozen, 0);
    tick();
    check("frozen_after_key1", frozen, 1);
    check("rx_ready_when_frozen", rx_ready, 1);
    tick();
    rx_valid = 1'b0;
    check("frozen_cur_pos", cur_pos, 0);
    read_cell(5'd0, d);
    check("frozen_cell0", d, 8'h20);
    $display("freeze: frozen=%0d cur_pos=%0d cell0=0x%02h", frozen, cur_pos, d);
    repeat (DEB + 6) tick();

    press_key(1);
    check("unfrozen_after_key1", frozen, 0);
    send(8'h46);
    check("unfrozen_cur_pos", cur_pos, 1);
    read_cell(5'd0, d);
    check("unfrozen_cell0", d, 8'h46);
    $display("unfreeze: frozen=%0d cur_pos=%0d cell0=0x%02h", frozen, cur_pos, d);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lcd_char_buf_ctrl.md
Name: lcd_char_buf_ctrl

Overview:
- Character-buffer controller between the RS485 receive path and the RGB LCD character display.
- Arbitrates two requesters for one COLS×ROWS text buffer:
  - received bytes from the RS485 receiver;
  - debounced key commands: clear, freeze, home, newline.
- Exposes a registered read port that the display pixel generator scans.
- Runs entirely in the sys_clk domain.

Parameters:
- COLS, 16: characters per row.
- ROWS, 2: number of rows. COLS*ROWS must be ≤ 32.
- DEB_CNT, 1_000_000: stable cycles required to accept a key level change (20 ms at 50 MHz).

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- key  in  4  raw push buttons, active-low, asynchronous
- rx_valid  in  1  received byte strobe
- rx_data  in  8  received byte
- rx_ready  out  1  byte accepted in any cycle where rx_valid && rx_ready
- rd_addr  in  5  display read address (row*COLS+col)
- rd_data  out  8  buffer character, 1-cycle latency
- cur_pos  out  5  current cursor address
- frozen  out  1  rx writes suppressed
- busy  out  1  clear sequence in progress

Behaviour:
- Reset: already decided — reset sys_rst_n, asynchronous, active-low; clock sys_clk.
  - Every buffer cell = 0x20.
  - cur_pos=0, frozen=0, busy=0, rd_data=0x20, state=IDLE, all debounced levels=1 (released).
  - Reset asserted mid-clear aborts the clear and restores these values.
- Key conditioning, per bit:
  - 2-FF synchronizer, then a counter that restarts on any difference from the debounced level.
  - Debounced level updates once the difference holds for DEB_CNT cycles.
  - A 1→0 debounced transition produces a one-cycle press pulse.
  - Same-cycle pulses: priority key0 > key1 > key2 > key3. Lower-priority pulses in that cycle are discarded.
- State machine IDLE / CLEAR:
  - IDLE, key0 pulse: enter CLEAR, set busy=1, clear index=0.
  - CLEAR: write 0x20 to cell index, one cell per cycle, cells 0..COLS*ROWS-1. After the last write: cur_pos=0, busy=0, return to IDLE. Duration is exactly COLS*ROWS cycles.
  - key0 during CLEAR: ignored.
- Other key commands:
  - key1 toggles frozen in any state.
  - key2 (IDLE only): cur_pos=0.
  - key3 (IDLE only): cur_pos = start of next row; the last row wraps to row 0.
- rx_ready:
  - High only in IDLE and only when no key pulse is being serviced that cycle. Keys win simultaneous events.
  - Accepted bytes are consumed even when frozen=1; the buffer and cursor are then unchanged.
- Accepted byte, frozen=0:
  - 0x20–0x7E: write at cur_pos; cur_pos+1, wrapping COLS*ROWS-1 → 0.
  - 0x0D: cur_pos = start of next row (wraps).
  - 0x0A: ignored.
  - 0x08: if cur_pos>0, cur_pos-1 and write 0x20 at the new position; at cur_pos=0, no change.
  - Any other value: write 0x3F ('?') and advance as for a printable byte.
- Buffer timing: the write lands on the acceptance edge. A read of that address issued on the next cycle returns the new value.
- Read port: rd_data <= buf[rd_addr] each edge. rd_addr ≥ COLS*ROWS returns 0x20.

Optional Feature:
- Macro RX_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt[7:0], reset 0.
  - Increments, saturating at 255, on every cycle with rx_valid=1 and rx_ready=0.
  - Cleared by the key0 clear command at CLEAR entry.
- Undefined: the port and counter are absent; dropped bytes are silently lost.

Test Plan:
- Reset release → rd_data=0x20 for all rd_addr 0..31, cur_pos=0, busy=0, rx_ready=1.
- Send 0x41, 0x42 → cells 0,1 = 0x41,0x42; cur_pos=2. Send 0x0D → cur_pos=16. Send 0x08 → cur_pos=15 and cell 15=0x20.
- Cursor at 31, send 0x43 → cell 31=0x43, cur_pos=0. Send 0x07 → cell 0=0x3F, cur_pos=1.
- key0 held low for DEB_CNT+2 cycles (DEB_CNT=8 in sim):
  - busy high for exactly 32 cycles and rx_ready low during them;
  - all cells 0x20 afterwards, cur_pos=0;
  - a glitch shorter than DEB_CNT produces no action.
- key1 pulse and rx_valid 0x44 in the same cycle → byte not accepted, frozen=1. Next cycle the byte is accepted with buffer unchanged. A second key1 pulse → frozen=0.
- RX_DROP_CNT_EN: rx_valid held during a 32-cycle clear → drop_cnt=32. Repeat until it saturates at 255.
